cla6_bist: RTL and testbench

CLA6_BIST -- requirements
Module: cla6_bist

---
 rtl/cla6_pkg.sv | 26 ++
 rtl/cla6_bist_chk.sv | 18 +
 rtl/cla6_bist.sv | 135 +++++++++++++
 tb/tb_cla6_bist.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla6_pkg.sv
// Shared definitions for the 6-bit carry-lookahead adder self-test.
package cla6_pkg;

  localparam int VEC_W   = 13;
  localparam int RES_W   = 7;
  localparam int OP_W    = 6;
  localparam int NUM_VEC = 8192;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Golden 7-bit result {cout,sum} for a vector laid out as {cin,a,b}.
  function automatic logic [RES_W-1:0] golden_res(input logic [VEC_W-1:0] vec);
    logic [RES_W-1:0] a_x;
    logic [RES_W-1:0] b_x;
    logic [RES_W-1:0] c_x;
    a_x = {1'b0, vec[11:6]};
    b_x = {1'b0, vec[5:0]};
    c_x = {6'd0, vec[12]};
    return a_x + b_x + c_x;
  endfunction

endpackage

// File: rtl/cla6_bist_chk.sv
// Combinational reference sum and compare against the adder under test.
module cla6_bist_chk
  import cla6_pkg::*;
(
  input  logic [VEC_W-1:0] vec,
  input  logic [OP_W-1:0]  s,
  input  logic             cout,
  output logic [RES_W-1:0] expected,
  output logic             mismatch
);

  // Expected result from the current vector, flagged when the adder disagrees.
  always_comb begin
    expected = golden_res(vec);
    mismatch = (expected != {cout, s});
  end

endmodule

// File: rtl/cla6_bist.sv
// Exhaustive self-test sequencer for an external 6-bit adder.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_IDLE | waiting for start; results of an aborted sweep are held
//   ST_RUN  | sweeping {cin,a,b} 0..8191, each vector held WAIT_CYC cycles
//   ST_DONE | sweep complete; done=1, pass valid, held until next start
module cla6_bist
  import cla6_pkg::*;
#(
  parameter int WAIT_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [OP_W-1:0]   a_o,
  output logic [OP_W-1:0]   b_o,
  output logic              cin_o,
  input  logic [OP_W-1:0]   s_i,
  input  logic              cout_i,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [13:0]       err_cnt,
  output logic [VEC_W-1:0]  fail_vec,
  output logic [RES_W-1:0]  fail_res
);

  localparam logic [3:0]       HOLD_LD  = 4'(WAIT_CYC - 1);
  localparam logic [VEC_W-1:0] VEC_LAST = VEC_W'(NUM_VEC - 1);

  state_t             state_q;
  state_t             state_d;
  logic [VEC_W-1:0]   vec_q;
  logic [3:0]         hold_q;
  logic [13:0]        err_q;
  logic [VEC_W-1:0]   fvec_q;
  logic [RES_W-1:0]   fres_q;
  logic               clr;
  logic               smp;
  logic               adv;
  logic               mismatch;
  logic [RES_W-1:0]   expected;

  cla6_bist_chk u_chk (
    .vec      (vec_q),
    .s        (s_i),
    .cout     (cout_i),
    .expected (expected),
    .mismatch (mismatch)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and control strobes; sampling happens when the hold timer hits zero.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    clr     = 1'b0;
    smp     = 1'b0;
    adv     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          clr     = 1'b1;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (abort) begin
          state_d = ST_IDLE;
        end else if (hold_q == 4'd0) begin
          smp = 1'b1;
          if (vec_q == VEC_LAST) state_d = ST_DONE;
          else                   adv     = 1'b1;
        end
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) begin
          state_d = ST_RUN;
          clr     = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Vector register and per-vector hold down-counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      vec_q  <= '0;
      hold_q <= '0;
    end else if (clr) begin
      vec_q  <= '0;
      hold_q <= HOLD_LD;
    end else if (adv) begin
      vec_q  <= vec_q + 1'b1;
      hold_q <= HOLD_LD;
    end else if (busy && hold_q != 4'd0) begin
      hold_q <= hold_q - 1'b1;
    end
  end

  // Error count (saturating) and first-failure capture.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      err_q  <= '0;
      fvec_q <= '0;
      fres_q <= '0;
    end else if (smp && mismatch) begin
      if (err_q != '1) err_q <= err_q + 1'b1;
      if (err_q == '0) begin
        fvec_q <= vec_q;
        fres_q <= {cout_i, s_i};
      end
    end
  end

  assign cin_o    = vec_q[12];
  assign a_o      = vec_q[11:6];
  assign b_o      = vec_q[5:0];
  assign pass     = done && (err_q == '0);
  assign err_cnt  = err_q;
  assign fail_vec = fvec_q;
  assign fail_res = fres_q;

endmodule

// File: tb/tb_cla6_bist.sv
// Bench for cla6_bist: a behavioural adder with injectable faults drives two
// instances (hold of 1 and 3 cycles); results are compared against a plain
// arithmetic model of the full sweep.
module tb_cla6_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start1, start3, abort1, abort3;
  logic [5:0]  a1, b1, s1, a3, b3, s3;
  logic        cin1, cout1, cin3, cout3;
  logic        busy1, done1, pass1, busy3, done3, pass3;
  logic [13:0] err1, err3;
  logic [12:0] fv1, fv3;
  logic [6:0]  fr1, fr3;
  logic [6:0]  r1, r3;

  logic [6:0]  and_mask;
  logic [6:0]  flip [0:8191];

  int n_checks = 0;
  int n_fail   = 0;

  cla6_bist #(.WAIT_CYC(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1),
    .a_o(a1), .b_o(b1), .cin_o(cin1), .s_i(s1), .cout_i(cout1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
    .fail_vec(fv1), .fail_res(fr1)
  );

  cla6_bist #(.WAIT_CYC(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .abort(abort3),
    .a_o(a3), .b_o(b3), .cin_o(cin3), .s_i(s3), .cout_i(cout3),
    .busy(busy3), .done(done3), .pass(pass3), .err_cnt(err3),
    .fail_vec(fv3), .fail_res(fr3)
  );

  // Adder under test, with stuck-at (and_mask) and per-vector flip faults.
  always_comb begin
    r1 = ((7'(a1) + 7'(b1) + 7'(cin1)) & and_mask) ^ flip[{cin1, a1, b1}];
    r3 = ((7'(a3) + 7'(b3) + 7'(cin3)) & and_mask) ^ flip[{cin3, a3, b3}];
  end
  assign {cout1, s1} = r1;
  assign {cout3, s3} = r3;

  task automatic clear_faults();
    and_mask = 7'h7F;
    for (int i = 0; i < 8192; i++) flip[i] = 7'h00;
  endtask

  // Expected outcome after the first n vectors of a sweep.
  task automatic ref_model(input int n, output int cnt, output logic [12:0] fv,
                           output logic [6:0] fr);
    cnt = 0; fv = '0; fr = '0;
    for (int v = 0; v < n; v++) begin
      int ci, aa, bb, good;
      logic [6:0] got;
      ci   = v / 4096;
      aa   = (v / 64) % 64;
      bb   = v % 64;
      good = aa + bb + ci;
      got  = (7'(good) & and_mask) ^ flip[v];
      if (got != 7'(good)) begin
        if (cnt == 0) begin
          fv = 13'(v);
          fr = got;
        end
        cnt++;
      end
    end
  endtask

  // Full sweep on the instance selected by w; optional start pulse while busy.
  task automatic run_sweep(input int w, input int start_at, input string name);
    int          busy_cyc, order_err, exp_cnt;
    logic [12:0] efv, vec;
    logic [6:0]  efr;
    logic        bsy, d_done, d_pass;
    logic [13:0] d_err;
    logic [12:0] d_fv;
    logic [6:0]  d_fr;
    bit          tmo;
    busy_cyc = 0; order_err = 0; tmo = 0;
    ref_model(8192, exp_cnt, efv, efr);
    @(negedge clk);
    start1 = (w == 1);
    start3 = (w != 1);
    @(negedge clk);
    start1 = 1'b0;
    start3 = 1'b0;
    while (1) begin
      bsy = (w == 1) ? busy1 : busy3;
      vec = (w == 1) ? {cin1, a1, b1} : {cin3, a3, b3};
      if (!bsy) break;
      if (vec != 13'(busy_cyc / w)) order_err++;
      busy_cyc++;
      start1 = (w == 1) && (busy_cyc == start_at);
      start3 = (w != 1) && (busy_cyc == start_at);
      if (busy_cyc > 30000) begin
        tmo = 1;
        break;
      end
      @(negedge clk);
    end
    start1 = 1'b0;
    start3 = 1'b0;
    n_checks++;
    if (tmo) begin n_fail++; $display("FAIL %s timeout: busy never dropped", name); end
    n_checks++;
    if (busy_cyc != 8192 * w) begin
      n_fail++; $display("FAIL %s busy_cycles: got %0d want %0d", name, busy_cyc, 8192 * w);
    end
    n_checks++;
    if (order_err != 0) begin
      n_fail++; $display("FAIL %s vector_order: got %0d bad cycles want 0", name, order_err);
    end
    for (int k = 0; k < 2; k++) begin
      d_done = (w == 1) ? done1 : done3;
      d_pass = (w == 1) ? pass1 : pass3;
      d_err  = (w == 1) ? err1  : err3;
      d_fv   = (w == 1) ? fv1   : fv3;
      d_fr   = (w == 1) ? fr1   : fr3;
      bsy    = (w == 1) ? busy1 : busy3;
      n_checks++;
      if (d_done !== 1'b1 || bsy !== 1'b0) begin
        n_fail++; $display("FAIL %s done/busy[%0d]: got %b/%b want 1/0", name, k, d_done, bsy);
      end
      n_checks++;
      if (d_pass !== (exp_cnt == 0)) begin
        n_fail++; $display("FAIL %s pass: got %b want %b", name, d_pass, exp_cnt == 0);
      end
      n_checks++;
      if (d_err !== 14'(exp_cnt)) begin
        n_fail++; $display("FAIL %s err_cnt: got %0d want %0d", name, d_err, exp_cnt);
      end
      n_checks++;
      if (d_fv !== efv || d_fr !== efr) begin
        n_fail++; $display("FAIL %s fail_vec/res: got %h/%h want %h/%h", name, d_fv, d_fr, efv, efr);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start1 = 1'b1; abort1 = 1'b1; start3 = 1'b1; abort3 = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({a1, b1, cin1, busy1, done1, pass1, err1, fv1, fr1} !== '0) begin
      n_fail++; $display("FAIL reset_dut1: got %h want 0",
                         {a1, b1, cin1, busy1, done1, pass1, err1, fv1, fr1});
    end
    n_checks++;
    if ({a3, b3, cin3, busy3, done3, pass3, err3, fv3, fr3} !== '0) begin
      n_fail++; $display("FAIL reset_dut3: got %h want 0",
                         {a3, b3, cin3, busy3, done3, pass3, err3, fv3, fr3});
    end
    start1 = 1'b0; abort1 = 1'b0; start3 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy1 !== 1'b0 || done1 !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_reset: got busy=%b done=%b want 0/0", busy1, done1);
    end
  endtask

  task automatic test_correct();
    clear_faults();
    run_sweep(1, -1, "correct_w1");
  endtask

  task automatic test_s0_stuck();
    clear_faults();
    and_mask = 7'h7E;
    run_sweep(1, -1, "s0_stuck");
    n_checks++;
    if (err1 !== 14'd4096 || fv1 !== 13'h0001 || fr1 !== 7'h00) begin
      n_fail++; $display("FAIL s0_stuck_const: got %0d/%h/%h want 4096/0001/00", err1, fv1, fr1);
    end
  endtask

  task automatic test_cout_stuck();
    clear_faults();
    and_mask = 7'h3F;
    run_sweep(1, -1, "cout_stuck");
    n_checks++;
    if (err1 !== 14'd4096 || fv1 !== {1'b0, 6'd1, 6'd63} || fr1 !== 7'h00) begin
      n_fail++; $display("FAIL cout_stuck_const: got %0d/%h/%h want 4096/007f/00", err1, fv1, fr1);
    end
  endtask

  task automatic test_random_faults();
    int nf;
    clear_faults();
    nf = $urandom_range(5, 40);
    for (int i = 0; i < nf; i++) flip[$urandom_range(0, 8191)] = 7'($urandom_range(1, 127));
    run_sweep(1, $urandom_range(2, 8000), "random_faults_start_busy");
  endtask

  task automatic test_abort();
    int          cyc, exp_cnt;
    logic [12:0] efv;
    logic [6:0]  efr;
    bit          dropped;
    clear_faults();
    and_mask = 7'h7E;
    ref_model(100, exp_cnt, efv, efr);
    cyc = 0; dropped = 0;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    while (cyc < 100) begin
      if (!busy1) dropped = 1;
      cyc++;
      @(negedge clk);
    end
    abort1 = 1'b1; start1 = 1'b1;
    @(negedge clk);
    abort1 = 1'b0; start1 = 1'b0;
    n_checks++;
    if (dropped) begin n_fail++; $display("FAIL abort_prebusy: got busy drop want steady busy"); end
    n_checks++;
    if (busy1 !== 1'b0 || done1 !== 1'b0 || pass1 !== 1'b0) begin
      n_fail++; $display("FAIL abort_idle: got busy=%b done=%b pass=%b want 0/0/0", busy1, done1, pass1);
    end
    n_checks++;
    if (err1 !== 14'(exp_cnt) || fv1 !== efv || fr1 !== efr) begin
      n_fail++; $display("FAIL abort_hold: got %0d/%h/%h want %0d/%h/%h", err1, fv1, fr1, exp_cnt, efv, efr);
    end
    abort1 = 1'b1;
    @(negedge clk);
    abort1 = 1'b0;
    n_checks++;
    if (busy1 !== 1'b0 || err1 !== 14'(exp_cnt)) begin
      n_fail++; $display("FAIL abort_in_idle: got busy=%b err=%0d want 0/%0d", busy1, err1, exp_cnt);
    end
    clear_faults();
    run_sweep(1, -1, "after_abort");
  endtask

  task automatic test_reset_mid();
    int          cyc, exp_cnt;
    logic [12:0] efv;
    logic [6:0]  efr;
    clear_faults();
    and_mask = 7'h3F;
    ref_model(500, exp_cnt, efv, efr);
    cyc = 0;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    while (cyc < 500 && busy1) begin
      cyc++;
      @(negedge clk);
    end
    n_checks++;
    if (busy1 !== 1'b1 || err1 !== 14'(exp_cnt)) begin
      n_fail++; $display("FAIL pre_reset: got busy=%b err=%0d want 1/%0d", busy1, err1, exp_cnt);
    end
    rst = 1'b1; start1 = 1'b1; abort1 = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({a1, b1, cin1, busy1, done1, pass1, err1, fv1, fr1} !== '0) begin
      n_fail++; $display("FAIL mid_reset: got %h want 0", {a1, b1, cin1, busy1, done1, pass1, err1, fv1, fr1});
    end
    rst = 1'b0; start1 = 1'b0; abort1 = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy1 !== 1'b0 || done1 !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_idle: got busy=%b done=%b want 0/0", busy1, done1);
    end
  endtask

  task automatic test_wait3();
    clear_faults();
    run_sweep(3, -1, "correct_w3");
  endtask

  initial begin
    rst = 1'b1; start1 = 1'b0; start3 = 1'b0; abort1 = 1'b0; abort3 = 1'b0;
    clear_faults();
    test_reset();
    test_correct();
    test_s0_stuck();
    test_cout_stuck();
    test_random_faults();
    test_abort();
    test_reset_mid();
    test_wait3();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
